// File: rtl/sm2201_pkg.sv
// sm2201_pkg: shared types and constants for the ISA-to-CAMAC bridge
package sm2201_pkg;

    typedef enum logic [1:0] {IDLE, XFER, TOUT, HOLD} state_t;

    localparam int STATUS_BACK = 1;
    localparam int IRQEN_BACK = 2;
    localparam logic [7:0] RD_ABORT = 8'hFF;

endpackage

// File: rtl/sm2201_sync2.sv
// sm2201_sync2: parametrised-width two-flop synchroniser with reset value
module sm2201_sync2 #(
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] m;

    // two-stage resync into the bus clock domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m <= RST_VAL;
            q <= RST_VAL;
        end else begin
            m <= d;
            q <= m;
        end
    end

endmodule

// File: rtl/sm2201_isa_camac_bridge.sv
// sm2201_isa_camac_bridge: ISA I/O window to 16-bit CAMAC transfers with local regs and LAM IRQs
module sm2201_isa_camac_bridge
    import sm2201_pkg::*;
#(
    parameter logic [9:0] BASE_ADDR = 10'h100,
    parameter int WIN_SIZE = 64,
    parameter int CB_DATA_W = 16,
    parameter int N_LAM = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 isa_clk,
    input  logic                 isa_reset,
    input  logic                 isa_ale,
    input  logic                 isa_aen,
    input  logic                 isa_ior,
    input  logic                 isa_iow,
    input  logic [9:0]           isa_addr,
    input  logic [7:0]           isa_data_in,
    output logic [7:0]           isa_data_out,
    output logic                 isa_data_oe,
    output logic                 isa_chrdy,
    output logic [N_LAM-1:0]     isa_irq,
    output logic [11:0]          cb_addr,
    output logic                 cb_wr,
    output logic                 cb_req,
    input  logic                 cb_ack,
    input  logic [CB_DATA_W-1:0] cb_data_in,
    output logic [CB_DATA_W-1:0] cb_data_out,
    input  logic [N_LAM-1:0]     cb_lam
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [10:0] END_ADDR = 11'(int'(BASE_ADDR) + WIN_SIZE);
    localparam logic [9:0] STATUS_OFF = 10'(WIN_SIZE - STATUS_BACK);
    localparam logic [9:0] IRQEN_OFF = 10'(WIN_SIZE - IRQEN_BACK);

    if (int'(BASE_ADDR) + WIN_SIZE > 1024 || WIN_SIZE < 4 || (WIN_SIZE & (WIN_SIZE - 1)) != 0 ||
        N_LAM < 1 || N_LAM > 7 || CB_DATA_W != 16 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("sm2201_isa_camac_bridge: illegal parameter set");
    end

    state_t st, n_st;
    logic ior_s, iow_s, ior_d, iow_d, ack_s;
    logic [N_LAM-1:0] lam_s, irq_en, n_irq_en;
    logic [9:0] addr_q, off;
    logic [TW-1:0] timer, n_timer;
    logic rd_q, n_rd, drop_q, n_drop, tout_q, n_tout;
    logic [7:0] lo_q, n_lo, hi_q, n_hi, n_dout, status;
    logic n_chrdy, n_req, n_wr;
    logic [11:0] n_caddr;
    logic [CB_DATA_W-1:0] n_cdout;
    logic rd_go, wr_go, hit, is_cam, strobe_hi;

    sm2201_sync2 #(.W(2), .RST_VAL(2'b11)) u_sync_strobe (
        .clk(isa_clk), .rst_n(isa_reset), .d({isa_ior, isa_iow}), .q({ior_s, iow_s})
    );

    sm2201_sync2 #(.W(N_LAM + 1), .RST_VAL('0)) u_sync_cb (
        .clk(isa_clk), .rst_n(isa_reset), .d({cb_lam, cb_ack}), .q({lam_s, ack_s})
    );

    assign rd_go = ior_d & ~ior_s & iow_s;
    assign wr_go = iow_d & ~iow_s & ior_s;
    assign off = addr_q - BASE_ADDR;
    assign hit = ~isa_aen && addr_q >= BASE_ADDR && {1'b0, addr_q} < END_ADDR;
    assign is_cam = off < IRQEN_OFF;
    assign strobe_hi = rd_q ? ior_s : iow_s;
    assign status = 8'({lam_s, tout_q});
    assign isa_data_oe = (st == HOLD) && rd_q && !drop_q;

    // next-state and datapath updates for the transfer FSM
    always_comb begin
        n_st = st;
        n_timer = timer;
        n_rd = rd_q;
        n_drop = drop_q;
        n_lo = lo_q;
        n_hi = hi_q;
        n_irq_en = irq_en;
        n_tout = tout_q;
        n_dout = isa_data_out;
        n_chrdy = isa_chrdy;
        n_req = cb_req;
        n_wr = cb_wr;
        n_caddr = cb_addr;
        n_cdout = cb_data_out;
        case (st)
            IDLE: if (hit && (rd_go || wr_go)) begin
                n_rd = rd_go;
                n_drop = 1'b0;
                n_st = HOLD;
                if (rd_go) begin
                    if (off == STATUS_OFF) begin
                        n_dout = status;
                        n_tout = 1'b0;
                    end else if (off == IRQEN_OFF) n_dout = 8'(irq_en);
                    else if (off[0]) n_dout = hi_q;
                end else begin
                    if (off == IRQEN_OFF) n_irq_en = isa_data_in[N_LAM-1:0];
                    else if (is_cam && !off[0]) n_lo = isa_data_in;
                    else if (is_cam) n_cdout = {isa_data_in, lo_q};
                end
                if (is_cam && (rd_go ^ off[0])) begin
                    n_st = XFER;
                    n_req = 1'b1;
                    n_wr = wr_go;
                    n_caddr = 12'(off >> 1);
                    n_chrdy = 1'b0;
                    n_timer = '0;
                end
            end
            XFER: begin
                n_drop = drop_q | strobe_hi;
                if (ack_s) begin
                    n_req = 1'b0;
                    n_chrdy = 1'b1;
                    n_st = HOLD;
                    if (rd_q && !n_drop) begin
                        n_dout = cb_data_in[7:0];
                        n_hi = cb_data_in[15:8];
                    end
                end else if (timer == T_LAST) begin
                    n_req = 1'b0;
                    n_chrdy = 1'b1;
                    n_tout = 1'b1;
                    n_st = TOUT;
                    if (rd_q && !n_drop) n_dout = RD_ABORT;
                end else n_timer = timer + 1'b1;
            end
            TOUT: n_st = HOLD;
            HOLD: n_st = strobe_hi ? IDLE : HOLD;
            default: n_st = IDLE;
        endcase
    end

    // state, registers and outputs; reset aborts any transfer in flight
    always_ff @(posedge isa_clk) begin
        if (!isa_reset) begin
            st <= IDLE;
            timer <= '0;
            rd_q <= 1'b0;
            drop_q <= 1'b0;
            lo_q <= '0;
            hi_q <= '0;
            irq_en <= '0;
            tout_q <= 1'b0;
            isa_data_out <= '0;
            isa_chrdy <= 1'b1;
            isa_irq <= '0;
            cb_req <= 1'b0;
            cb_wr <= 1'b0;
            cb_addr <= '0;
            cb_data_out <= '0;
            ior_d <= 1'b1;
            iow_d <= 1'b1;
            addr_q <= '0;
        end else begin
            st <= n_st;
            timer <= n_timer;
            rd_q <= n_rd;
            drop_q <= n_drop;
            lo_q <= n_lo;
            hi_q <= n_hi;
            irq_en <= n_irq_en;
            tout_q <= n_tout;
            isa_data_out <= n_dout;
            isa_chrdy <= n_chrdy;
            isa_irq <= lam_s & irq_en;
            cb_req <= n_req;
            cb_wr <= n_wr;
            cb_addr <= n_caddr;
            cb_data_out <= n_cdout;
            ior_d <= ior_s;
            iow_d <= iow_s;
            if (isa_ale && !isa_aen) addr_q <= isa_addr;
        end
    end

endmodule
